// File: rtl/hamming_pkg.sv
// Shared constants and state type for the Hamming codec frame sequencer.
package hamming_pkg;
    localparam int CDC_DATA_W  = 8;
    localparam int CDC_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;
endpackage

// File: rtl/hamming_ctrl_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is visible whenever the FIFO is not empty.
module hamming_ctrl_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_din,
    input  logic                   i_pop,
    output logic [W-1:0]           o_dout,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          w_full;

    assign w_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    // Empty head reads as zero so the sink never sees stale data.
    assign o_dout  = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_pop && w_full));
endmodule

// File: rtl/hamming_codec_ctrl.sv
// Frame sequencer around an external 12/8 Hamming codec: credit-gated intake, tag pipeline
// tracking codec latency, FWFT output FIFO and byte/frame status counters.
import hamming_pkg::*;

module hamming_codec_ctrl #(
    parameter int DATA_W     = CDC_DATA_W,
    parameter int LATENCY    = CDC_LATENCY,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] cdc_data,
    input  logic [DATA_W-1:0] cdc_q,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  byte_cnt,
    output logic [CNT_W-1:0]  frame_cnt
);
    localparam int SW = $clog2(FIFO_DEPTH + LATENCY + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e              r_state;
    logic                r_busy;
    logic                r_rdy_en;
    logic [LATENCY-1:0]  r_tag_vld;
    logic [LATENCY-1:0]  r_tag_last;
    logic [CNT_W-1:0]    r_byte_cnt;
    logic [CNT_W-1:0]    r_frame_cnt;

    logic                w_fire;
    logic                w_pop;
    logic                w_empty;
    logic [CW-1:0]       w_fifo_cnt;
    logic [SW-1:0]       w_inflight;
    logic [SW-1:0]       w_occ;
    logic [DATA_W:0]     w_head;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LATENCY; i++)
            w_inflight = w_inflight + SW'(r_tag_vld[i]);
    end

    // Every in-flight byte already owns a FIFO slot, so a stalled sink can never cause loss.
    assign w_occ    = w_inflight + SW'(w_fifo_cnt);
    assign s_ready  = r_rdy_en && (r_state != DRAIN) && (w_occ < SW'(FIFO_DEPTH));
    assign w_fire   = s_valid && s_ready;
    assign cdc_data = w_fire ? s_data : '0;

    assign m_valid   = !w_empty;
    assign m_data    = w_head[DATA_W-1:0];
    assign m_last    = w_head[DATA_W];
    assign w_pop     = m_valid && m_ready;
    assign busy      = r_busy;
    assign byte_cnt  = r_byte_cnt;
    assign frame_cnt = r_frame_cnt;

    // r_rdy_en keeps s_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en   <= 1'b0;
            r_tag_vld  <= '0;
            r_tag_last <= '0;
        end else begin
            r_rdy_en      <= 1'b1;
            r_tag_vld[0]  <= w_fire;
            r_tag_last[0] <= s_last;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_last[i] <= r_tag_last[i-1];
            end
        end
    end

    hamming_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_tag_vld[LATENCY-1]),
        .i_din   ({r_tag_last[LATENCY-1], cdc_q}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_count (w_fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_fire) begin
                    r_state <= s_last ? DRAIN : RUN;
                    r_busy  <= 1'b1;
                end
                RUN: if (w_fire && s_last) r_state <= DRAIN;
                DRAIN: if (w_pop && m_last) begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_byte_cnt <= '0;
        else if (w_pop) r_byte_cnt <= r_byte_cnt + 1'b1;
    end
endmodule

// File: tb/tb_hamming_codec_ctrl.sv
// Bench for hamming_codec_ctrl: loopback codec plus a queue-based reference of accepted bytes.
module tb_hamming_codec_ctrl;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready, m_valid, m_last, busy;
    logic [7:0]  cdc_data, cdc_q, m_data;
    logic [15:0] byte_cnt, frame_cnt;

    always #5 clk = ~clk;

    hamming_codec_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .cdc_data(cdc_data), .cdc_q(cdc_q),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .byte_cnt(byte_cnt), .frame_cnt(frame_cnt)
    );

    // Loopback codec: q is data delayed LAT cycles.
    logic [7:0] lb [LAT];
    always @(posedge clk) begin
        lb[0] <= cdc_data;
        for (int i = 1; i < LAT; i++) lb[i] <= lb[i-1];
    end
    assign cdc_q = lb[LAT-1];

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         t;
    } ent_t;

    ent_t        q[$];
    int          e = 0;
    bit          rdy_en, drain, inframe, fired, popped, dut_fire;
    logic [15:0] mb, mf;
    int          npass = 0, ntot = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic mreset();
        q.delete();
        drain = 0; inframe = 0; rdy_en = 0; mb = '0; mf = '0;
    endtask

    task automatic cyc(input bit v, input logic [7:0] d, input bit l, input bit mr);
        bit         er, emv;
        ent_t       h;
        s_valid = v; s_data = d; s_last = l; m_ready = mr;
        if (!rst_n) mreset();
        #1;
        er  = rdy_en && !drain && (q.size() < DEPTH);
        emv = (q.size() > 0) && (e >= q[0].t + LAT);
        chk("s_ready",   32'(s_ready),   32'(er));
        chk("m_valid",   32'(m_valid),   32'(emv));
        chk("m_data",    32'(m_data),    emv ? 32'(q[0].d) : 32'h0);
        chk("m_last",    32'(m_last),    emv ? 32'(q[0].l) : 32'h0);
        chk("cdc_data",  32'(cdc_data),  (v && er) ? 32'(d) : 32'h0);
        chk("busy",      32'(busy),      32'(inframe));
        chk("byte_cnt",  32'(byte_cnt),  32'(mb));
        chk("frame_cnt", 32'(frame_cnt), 32'(mf));
        dut_fire = s_valid && s_ready;
        fired    = v && er;
        popped   = emv && mr;
        @(posedge clk);
        if (rst_n) begin
            e++;
            if (popped) begin
                h = q.pop_front();
                mb++;
                if (h.l) begin mf++; drain = 0; inframe = 0; end
            end
            if (fired) begin
                q.push_back('{d, l, e});
                inframe = 1;
                if (l) drain = 1;
            end
            rdy_en = 1;
        end
        @(negedge clk);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 40 && (q.size() > 0 || inframe); i++) cyc(0, 8'h00, 0, 1);
        chk("idle_after_drain", 32'(busy), 32'h0);
    endtask

    initial begin
        int n;
        mreset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (10) cyc(0, 8'h00, 0, 0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        cyc(0, 8'h00, 0, 0);
        chk("rst_release_ready", 32'(s_ready), 32'h1);

        cyc(1, 8'h11, 0, 1);
        cyc(1, 8'h22, 0, 1);
        cyc(1, 8'h33, 1, 1);
        drain_all();
        chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("f1_byte_cnt",  32'(byte_cnt),  32'd3);

        n = 0;
        for (int c = 0; c < 12; c++) begin
            cyc(1, 8'(8'h40 + n), n == 7, 0);
            if (dut_fire) n++;
        end
        chk("stall_accepts", n, 4);
        for (int c = 0; c < 40 && n < 8; c++) begin
            cyc(1, 8'(8'h40 + n), n == 7, 1);
            if (dut_fire) n++;
        end
        chk("stall_all_accepted", n, 8);
        drain_all();
        chk("f2_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("f2_byte_cnt",  32'(byte_cnt),  32'd11);

        cyc(1, 8'hA5, 1, 1);
        chk("single_busy", 32'(busy), 32'h1);
        drain_all();
        chk("single_frame_cnt", 32'(frame_cnt), 32'd3);

        cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h02, 1, 0);
        repeat (5) cyc(1, 8'h03, 1, 0);
        chk("drain_blocks", 32'(s_ready), 32'h0);
        for (int c = 0; c < 20; c++) begin
            cyc(1, 8'h03, 1, 1);
            if (dut_fire) break;
        end
        drain_all();
        chk("drain_frame_cnt", 32'(frame_cnt), 32'd5);

        repeat (400) cyc($urandom_range(0, 3) != 0, 8'($urandom),
                         $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
        for (int c = 0; c < 60; c++) begin
            cyc(1, 8'hEE, 1, 1);
            if (dut_fire) break;
        end
        drain_all();

        cyc(1, 8'hC1, 0, 0);
        cyc(1, 8'hC2, 0, 0);
        cyc(1, 8'hC3, 0, 0);
        rst_n = 1'b0;
        cyc(0, 8'h00, 0, 1);
        chk("midrst_m_valid", 32'(m_valid), 32'h0);
        cyc(0, 8'h00, 0, 1);
        rst_n = 1'b1;
        repeat (3) cyc(0, 8'h00, 0, 1);
        chk("midrst_byte_cnt", 32'(byte_cnt), 32'h0);
        cyc(1, 8'h5A, 1, 1);
        drain_all();
        chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("post_rst_byte_cnt",  32'(byte_cnt),  32'd1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
